traffic_light_monitor: RTL

- Safety/conformance checker on the far side of the intersection controller's lamp outputs.
- Samples the six lamp lines and the side-road sensor each second and decodes the lamp pattern back into a phase.
- Checks phase order and dwell times against the timing contract, then latches the first violation with a code.
- Feeds a fault LED and the debug display; it never drives the lamps.

---
 rtl/traffic_light_monitor_pkg.sv | 42 ++++
 rtl/traffic_light_monitor_decode.sv | 27 ++
 rtl/traffic_light_monitor.sv | 118 +++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: phase codes (same values
// as the controller's state register), the four legal lamp patterns, the
// violation codes and the phase successor function.
package traffic_light_monitor_pkg;

  localparam logic [1:0] P0 = 2'b00;  // main green, side red
  localparam logic [1:0] P1 = 2'b01;  // main yellow, side red
  localparam logic [1:0] P2 = 2'b11;  // main red, side green
  localparam logic [1:0] P3 = 2'b10;  // main red, side yellow

  // Lamp bit order is {HG,HY,HR,FG,FY,FR}
  localparam logic [5:0] LAMP_P0 = 6'b100001;
  localparam logic [5:0] LAMP_P1 = 6'b010001;
  localparam logic [5:0] LAMP_P2 = 6'b001100;
  localparam logic [5:0] LAMP_P3 = 6'b001010;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_ILLEGAL    = 3'd1;
  localparam logic [2:0] FC_ORDER      = 3'd2;
  localparam logic [2:0] FC_YELLOW     = 3'd3;
  localparam logic [2:0] FC_MAIN_SHORT = 3'd4;
  localparam logic [2:0] FC_SIDE_LONG  = 3'd5;
  localparam logic [2:0] FC_UNREQ      = 3'd6;

  // Only legal successor of each phase: P0->P1->P2->P3->P0
  function automatic logic [1:0] nextPhase(input logic [1:0] p);
    logic [1:0] n;
    n = P0;
    case (p)
      P0:      n = P1;
      P1:      n = P2;
      P2:      n = P3;
      default: n = P0;
    endcase
    return n;
  endfunction

  function automatic logic isYellow(input logic [1:0] p);
    return (p == P1) || (p == P3);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_decode.sv
// Combinational lamp-pattern decoder: maps the six lamp lines to a phase code
// plus a valid flag. Any pattern other than the four legal ones is invalid.
module traffic_light_decode
  import traffic_light_monitor_pkg::*;
(
  input  logic [5:0] lamps,
  output logic       valid,
  output logic [1:0] phase
);

  // Exact match against the four legal patterns; everything else is illegal
  always_comb begin
    valid = 1'b1;
    phase = P0;
    case (lamps)
      LAMP_P0: phase = P0;
      LAMP_P1: phase = P1;
      LAMP_P2: phase = P2;
      LAMP_P3: phase = P3;
      default: begin
        valid = 1'b0;
        phase = P0;
      end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light conformance monitor. Samples the controller's lamp outputs
// once per second, tracks the decoded phase and its dwell, and latches the
// first timing/ordering violation into Fault/FaultCode (sticky until RESET).
// Build option: define MONITOR_STATS_EN to count completed P3->P0 cycles on
// CycleCount; otherwise CycleCount is tied to zero.
//
//   Phase | meaning
//   ------+------------------------------
//   P0 00 | main green, side red
//   P1 01 | main yellow, side red
//   P2 11 | main red, side green
//   P3 10 | main red, side yellow
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int YELLOW_TIME    = 5,
  parameter int MAIN_GREEN_MIN = 60,
  parameter int SIDE_GREEN_MAX = 30,
  parameter int DWELL_W        = 7
) (
  input  logic               CLK_1HzOut,
  input  logic               RESET,
  input  logic               HG,
  input  logic               HY,
  input  logic               HR,
  input  logic               FG,
  input  logic               FY,
  input  logic               FR,
  input  logic               S,
  output logic [1:0]         Phase,
  output logic [DWELL_W-1:0] Dwell,
  output logic               Fault,
  output logic [2:0]         FaultCode,
  output logic [7:0]         CycleCount
);

  localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] YELLOW_D   = DWELL_W'(YELLOW_TIME);
  localparam logic [DWELL_W-1:0] MAIN_MIN_D = DWELL_W'(MAIN_GREEN_MIN);
  localparam logic [DWELL_W-1:0] SIDE_MAX_D = DWELL_W'(SIDE_GREEN_MAX);

  logic [5:0]         lamps;
  logic               patValid;
  logic [1:0]         patPhase;
  logic               sQ;
  logic [DWELL_W-1:0] dwellNext;
  logic               phaseChange;
  logic [2:0]         code;

  assign lamps       = {HG, HY, HR, FG, FY, FR};
  assign phaseChange = patValid && (patPhase != Phase);

  traffic_light_decode uDecode (
    .lamps (lamps),
    .valid (patValid),
    .phase (patPhase)
  );

  // Classify this sample; the if-chain order gives the lowest code priority
  always_comb begin
    dwellNext = (Dwell == DWELL_MAX) ? Dwell : Dwell + 1'b1;
    code      = FC_NONE;
    if (!patValid) begin
      code = FC_ILLEGAL;
    end else if (!phaseChange) begin
      // Overrun checks fire on the sample that first exceeds the limit;
      // comparing with > keeps them armed even once Dwell saturates.
      if (isYellow(Phase) && (dwellNext > YELLOW_D))
        code = FC_YELLOW;
      else if ((Phase == P2) && (dwellNext > SIDE_MAX_D))
        code = FC_SIDE_LONG;
    end else begin
      // Exit checks judge the phase being left, using its final dwell
      if (patPhase != nextPhase(Phase))
        code = FC_ORDER;
      else if (isYellow(Phase) && (Dwell != YELLOW_D))
        code = FC_YELLOW;
      else if ((Phase == P0) && (Dwell < MAIN_MIN_D))
        code = FC_MAIN_SHORT;
      else if ((Phase == P0) && !sQ)
        code = FC_UNREQ;
    end
  end

  // Phase/dwell tracking and first-violation latch
  always_ff @(posedge CLK_1HzOut or negedge RESET) begin
    if (!RESET) begin
      Phase     <= P0;
      Dwell     <= '0;
      Fault     <= 1'b0;
      FaultCode <= FC_NONE;
      sQ        <= 1'b0;
    end else begin
      sQ    <= S;
      Dwell <= phaseChange ? DWELL_ONE : dwellNext;
      if (patValid)
        Phase <= patPhase;
      if (!Fault && (code != FC_NONE)) begin
        Fault     <= 1'b1;
        FaultCode <= code;
      end
    end
  end

`ifdef MONITOR_STATS_EN
  // Count legal P3->P0 wraps; 8-bit counter rolls over naturally
  always_ff @(posedge CLK_1HzOut or negedge RESET) begin
    if (!RESET)
      CycleCount <= '0;
    else if (phaseChange && (Phase == P3) && (patPhase == P0))
      CycleCount <= CycleCount + 8'd1;
  end
`else
  assign CycleCount = '0;
`endif

endmodule
